polybius_decryptor: RTL and testbench
=====================================

Name: polybius_decryptor

Overview:
- Downstream stage of the Polybius-square encryptor.
- Consumes the encryptor's ciphertext stream, one byte per character. Each byte encodes row*10+col, with row and col in 1..5.
- Rebuilds the keyed 5x5 square from a SEC_LEN-character secret, then decodes MSG_LEN codes per message back to uppercase ASCII.
- Valid/ready handshakes on the key, code and char interfaces.

Parameters:
- MSG_LEN, 6, characters per message; msg_done pulses after this many chars are output.
- SEC_LEN, 3, key characters accepted per key load.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rekey  input  1  single-cycle pulse; discards the square and enters KEY_LOAD.
- key_valid  input  1  key_char valid.
- key_char  input  8  key character, ASCII.
- key_ready  output  1  high only in KEY_LOAD.
- code_valid  input  1  code_in valid.
- code_in  input  8  ciphertext code, row*10+col.
- code_ready  output  1  decryptor accepts code_in this cycle.
- char_valid  output  1  char_out valid.
- char_out  output  8  decoded ASCII character.
- char_ready  input  1  consumer accepts char_out.
- err  output  1  sticky; set by any invalid code.
- msg_done  output  1  one-cycle pulse when the MSG_LEN-th char is accepted.
- busy  output  1  high in KEY_LOAD and FILL.

Behaviour:
- Reset (async, rst=1):
  - state=KEY_LOAD; square cleared; used[25:0] cleared.
  - Key count, fill pointer, square write pointer and message count all 0.
  - key_ready=0 while rst=1, then 1 after reset deasserts.
  - code_ready=0, char_valid=0, char_out=0, err=0, msg_done=0, busy=1.
- States: KEY_LOAD -> FILL -> DECODE. rekey in any state -> KEY_LOAD with the reset actions, except err is kept. rekey has priority over every other event in that cycle.
- KEY_LOAD:
  - Each cycle with key_valid&key_ready consumes one char and increments key count.
  - 'J' is mapped to 'I'.
  - If the char is A..Z and not yet used, it is written to square[wptr], wptr++, and its used bit is set.
  - Non-letters and duplicates are consumed and dropped.
  - After SEC_LEN chars -> FILL, with fill pointer at 'A'.
- FILL:
  - One letter per cycle, A..Z, 26 cycles exactly.
  - Letters other than 'J' that are not in used are appended at wptr.
  - After 'Z': wptr must equal 25 -> DECODE, busy=0.
- DECODE:
  - code_ready = !char_valid | char_ready (one-entry output register).
  - Handshake on code_valid&code_ready: row=code_in/10, col=code_in%10.
  - If row and col are both in 1..5: char_out = square[(row-1)*5 + (col-1)].
  - Otherwise char_out = 0x3F ('?') and err is set.
  - char_valid rises the cycle after acceptance (latency 1).
  - char_valid and char_out hold stable until char_ready. A simultaneous char_ready and new code accept sustains 1 char/cycle.
  - Each accepted char (char_valid&char_ready) increments the message count. At MSG_LEN, msg_done pulses that cycle and the count wraps to 0. The square is retained for the next message.
- Codes presented during KEY_LOAD or FILL are not accepted (code_ready=0).
- err is cleared only by rst.

Test Plan:
- Key "KEY", then codes 25,12,32,32,35,11 with char_ready=1 -> chars 'H','E','L','L','O','K' at 1/cycle. Expect msg_done on the 6th accept, err=0, busy high for 3+26 cycles.
- Key "JIJ" -> square starts I,A,B,C,D,E; code 11->'I', 12->'A', 55->'Z'. The first 'J' is written as 'I'; the later 'I' and 'J' are dropped as duplicates.
- Key "KEY", code 60 then code 06 -> char_out '?' both times; err=1 and stays 1; next code 21 -> 'C'.
- Backpressure: char_ready=0 for 3 cycles with code_valid=1 -> char_out held at first char, code_ready=0; release -> remaining chars in order, none lost or duplicated.
- rst asserted after the 3rd char of a message -> all outputs at reset values immediately. After re-key "KEY", a full 6-code message yields msg_done on the 6th char.
- rekey pulse while char_valid=1 -> char_valid drops, state KEY_LOAD, err unchanged; code_valid ignored until FILL completes.

Source files
------------

// File: rtl/polybius_decryptor.sv
// Polybius-square decryptor: rebuilds the keyed 5x5 square from a short secret, then maps
// row*10+col ciphertext codes back to uppercase ASCII through a one-entry output register.
module polybius_decryptor #(
    parameter int unsigned MSG_LEN = 6,
    parameter int unsigned SEC_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rekey,
    input  logic       key_valid,
    input  logic [7:0] key_char,
    output logic       key_ready,
    input  logic       code_valid,
    input  logic [7:0] code_in,
    output logic       code_ready,
    output logic       char_valid,
    output logic [7:0] char_out,
    input  logic       char_ready,
    output logic       err,
    output logic       msg_done,
    output logic       busy
);

    localparam int unsigned KeyW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
    localparam int unsigned MsgW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    typedef enum logic [1:0] {StKeyLoad, StFill, StDecode} state_e;

    state_e            state_q, state_d;
    logic [7:0]        square_q [25];
    logic [25:0]       used_q;
    logic [KeyW-1:0]   key_cnt_q;
    logic [4:0]        fill_ptr_q;
    logic [4:0]        wptr_q;
    logic [MsgW-1:0]   msg_cnt_q;
    logic              char_valid_q;
    logic [7:0]        char_out_q;
    logic              err_q;

    logic              key_fire, key_last, code_fire, out_fire, msg_last;
    logic [7:0]        key_norm;
    logic              key_is_letter;
    logic [4:0]        key_idx;
    logic              fill_take;
    logic [7:0]        row, col;
    logic              code_ok;
    logic [4:0]        sq_idx;
    logic [7:0]        dec_char;

    // Key normalisation, fill selection and code decode
    always_comb begin
        key_norm      = (key_char == 8'h4A) ? 8'h49 : key_char;
        key_is_letter = (key_norm >= 8'h41) && (key_norm <= 8'h5A);
        key_idx       = 5'(key_norm - 8'h41);
        key_fire      = key_valid && key_ready;
        key_last      = key_cnt_q == KeyW'(SEC_LEN - 1);
        fill_take     = (fill_ptr_q != 5'd9) && !used_q[fill_ptr_q];
        row           = code_in / 8'd10;
        col           = code_in % 8'd10;
        code_ok       = (row >= 8'd1) && (row <= 8'd5) && (col >= 8'd1) && (col <= 8'd5);
        sq_idx        = '0;
        if (code_ok) begin
            sq_idx = 5'((row[4:0] - 5'd1) * 5'd5 + col[4:0] - 5'd1);
        end
        dec_char      = code_ok ? square_q[sq_idx] : 8'h3F;
        code_fire     = code_valid && code_ready;
        out_fire      = char_valid_q && char_ready && !rekey;
        msg_last      = msg_cnt_q == MsgW'(MSG_LEN - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StKeyLoad;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rekey) begin
            state_d = StKeyLoad;
        end else begin
            unique case (state_q)
                StKeyLoad: if (key_fire && key_last) state_d = StFill;
                StFill:    if (fill_ptr_q == 5'd25) state_d = StDecode;
                StDecode:  state_d = StDecode;
                default:   state_d = StKeyLoad;
            endcase
        end
    end

    always_comb begin
        key_ready  = (state_q == StKeyLoad) && !rst;
        busy       = state_q != StDecode;
        // rekey wins, so no code is taken in a cycle whose result would be discarded
        code_ready = (state_q == StDecode) && !rekey && (!char_valid_q || char_ready);
        char_valid = char_valid_q;
        char_out   = char_out_q;
        err        = err_q;
        msg_done   = out_fire && msg_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (!rekey && code_fire && !code_ok) begin
            err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 25; i++) square_q[i] <= '0;
            used_q       <= '0;
            key_cnt_q    <= '0;
            fill_ptr_q   <= '0;
            wptr_q       <= '0;
            msg_cnt_q    <= '0;
            char_valid_q <= 1'b0;
            char_out_q   <= '0;
        end else if (rekey) begin
            for (int i = 0; i < 25; i++) square_q[i] <= '0;
            used_q       <= '0;
            key_cnt_q    <= '0;
            fill_ptr_q   <= '0;
            wptr_q       <= '0;
            msg_cnt_q    <= '0;
            char_valid_q <= 1'b0;
            char_out_q   <= '0;
        end else begin
            if (state_q == StKeyLoad && key_fire) begin
                key_cnt_q <= key_last ? '0 : key_cnt_q + 1'b1;
                if (key_is_letter && !used_q[key_idx]) begin
                    square_q[wptr_q] <= key_norm;
                    used_q[key_idx]  <= 1'b1;
                    wptr_q           <= wptr_q + 5'd1;
                end
            end
            if (state_q == StFill) begin
                fill_ptr_q <= fill_ptr_q + 5'd1;
                if (fill_take) begin
                    square_q[wptr_q]   <= 8'h41 + {3'b000, fill_ptr_q};
                    used_q[fill_ptr_q] <= 1'b1;
                    wptr_q             <= wptr_q + 5'd1;
                end
            end
            if (out_fire) begin
                char_valid_q <= 1'b0;
                msg_cnt_q    <= msg_last ? '0 : msg_cnt_q + 1'b1;
            end
            if (code_fire) begin
                char_valid_q <= 1'b1;
                char_out_q   <= dec_char;
            end
        end
    end

endmodule

// File: tb/tb_polybius_decryptor.sv
// Bench for polybius_decryptor: directed scenarios plus random keys/codes scored against a
// string-level model of the keyed square.
module tb_polybius_decryptor;

    localparam int MSG_LEN = 6;
    localparam int SEC_LEN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rekey = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_char = '0;
    logic       key_ready;
    logic       code_valid = 1'b0;
    logic [7:0] code_in = '0;
    logic       code_ready;
    logic       char_valid;
    logic [7:0] char_out;
    logic       char_ready = 1'b0;
    logic       err;
    logic       msg_done;
    logic       busy;

    polybius_decryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .rekey     (rekey),
        .key_valid (key_valid),
        .key_char  (key_char),
        .key_ready (key_ready),
        .code_valid(code_valid),
        .code_in   (code_in),
        .code_ready(code_ready),
        .char_valid(char_valid),
        .char_out  (char_out),
        .char_ready(char_ready),
        .err       (err),
        .msg_done  (msg_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sq [25];
    logic       model_err = 1'b0;
    int         acc_cnt = 0;
    int         last_cyc = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         code_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void model_key(input string k);
        bit used [26];
        int w = 0;
        int c;
        for (int i = 0; i < 26; i++) used[i] = 1'b0;
        for (int i = 0; i < k.len(); i++) begin
            c = int'(k[i]);
            if (c == 74) c = 73;
            if (c >= 65 && c <= 90 && !used[c-65]) begin
                sq[w] = 8'(c);
                w++;
                used[c-65] = 1'b1;
            end
        end
        for (int l = 0; l < 26; l++) begin
            if (l != 9 && !used[l]) begin
                sq[w] = 8'(65 + l);
                w++;
            end
        end
    endfunction

    function automatic bit code_bad(input int code);
        int r = code / 10;
        int c = code % 10;
        return !(r >= 1 && r <= 5 && c >= 1 && c <= 5);
    endfunction

    function automatic logic [7:0] model_dec(input int code);
        if (code_bad(code)) return 8'h3F;
        return sq[(code / 10 - 1) * 5 + (code % 10) - 1];
    endfunction

    task automatic reset_checks();
        chk("rst_key_ready", key_ready, 0);
        chk("rst_code_ready", code_ready, 0);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_char_out", char_out, 0);
        chk("rst_err", err, 0);
        chk("rst_msg_done", msg_done, 0);
        chk("rst_busy", busy, 1);
    endtask

    // Feeds the key one char per cycle, then times the fill phase; caller's code_valid stays up.
    task automatic load_key(input string k);
        int cyc = 0;
        for (int i = 0; i < k.len(); i++) begin
            key_valid = 1'b1;
            key_char  = k[i];
            #1;
            chk("key_ready", key_ready, 1);
            chk("code_ready_load", code_ready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        key_valid = 1'b0;
        while (busy === 1'b1 && cyc < 100) begin
            chk("code_ready_fill", code_ready, 0);
            chk("char_valid_fill", char_valid, 0);
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        code_valid = 1'b0;
        chk("fill_cycles", cyc, 26);
        model_key(k);
        acc_cnt = 0;
        exp_q.delete();
    endtask

    task automatic do_rekey();
        rekey = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rekey = 1'b0;
        #1;
        chk("rekey_char_valid", char_valid, 0);
        chk("rekey_key_ready", key_ready, 1);
        chk("rekey_busy", busy, 1);
        chk("rekey_err_kept", err, model_err);
    endtask

    // Streams code_q into the DUT and scores every output against the model.
    task automatic run_codes(input int ready_pct, input int stop_after);
        int cyc = 0;
        int accepted = 0;
        got_q.delete();
        while ((code_q.size() > 0 || char_valid === 1'b1) && cyc < 400 &&
               !(stop_after > 0 && accepted >= stop_after)) begin
            code_valid = code_q.size() > 0;
            if (code_valid) code_in = 8'(code_q[0]);
            else code_in = 8'h00;
            char_ready = ($urandom_range(99) < ready_pct);
            #1;
            chk("code_ready", code_ready, 32'(!char_valid || char_ready));
            if (char_valid && char_ready) begin
                got_q.push_back(char_out);
                if (exp_q.size() == 0) chk("char_extra", exp_q.size(), 1);
                else chk("char_out", char_out, exp_q.pop_front());
                acc_cnt++;
                accepted++;
                chk("msg_done", msg_done, 32'(acc_cnt == MSG_LEN));
                if (acc_cnt == MSG_LEN) acc_cnt = 0;
            end else begin
                chk("msg_done_idle", msg_done, 0);
            end
            if (code_valid && code_ready) begin
                exp_q.push_back(model_dec(code_q[0]));
                if (code_bad(code_q[0])) model_err = 1'b1;
                void'(code_q.pop_front());
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        code_valid = 1'b0;
        char_ready = 1'b0;
        last_cyc = cyc;
        chk("run_bound", 32'(cyc < 400), 1);
        chk("err", err, model_err);
        if (stop_after == 0) chk("exp_drained", exp_q.size(), 0);
    endtask

    task automatic check_got(input string tag, input string s);
        chk({tag, "_len"}, got_q.size(), s.len());
        for (int i = 0; i < s.len(); i++) begin
            chk(tag, (got_q.size() > i) ? got_q[i] : 8'h00, s[i]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string k;
        int    r;
        logic [7:0] kc [3];

        // Reset values
        @(negedge clk);
        reset_checks();
        rst = 1'b0;
        #1;
        chk("key_ready_after_rst", key_ready, 1);

        // HELLO with key KEY, full rate
        load_key("KEY");
        code_q = '{25, 12, 32, 32, 35, 11};
        run_codes(100, 0);
        check_got("hello", "HELLOK");
        chk("hello_rate", last_cyc, 7);

        // J folds onto I; later I/J are duplicates
        do_rekey();
        load_key("JIJ");
        code_q = '{11, 12, 55};
        run_codes(100, 0);
        check_got("jij", "IAZ");

        // Invalid codes give '?' and a sticky err
        do_rekey();
        load_key("KEY");
        code_q = '{60, 6, 21};
        run_codes(100, 0);
        check_got("invalid", "??C");
        chk("err_sticky", err, 1);

        // rekey while a char is pending; codes refused until fill completes
        code_valid = 1'b1;
        code_in    = 8'd11;
        char_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pending_char_valid", char_valid, 1);
        code_valid = 1'b0;
        do_rekey();
        code_valid = 1'b1;
        code_in    = 8'd11;
        load_key("KEY");
        #1;
        chk("no_char_after_load", char_valid, 0);
        chk("err_after_rekey", err, 1);

        // Backpressure: output held, input stalled, nothing lost
        code_valid = 1'b1;
        code_in    = 8'd25;
        char_ready = 1'b0;
        chk("bp_first_ready", code_ready, 1);
        @(posedge clk);
        @(negedge clk);
        code_in = 8'd12;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", char_valid, 1);
            chk("bp_hold", char_out, 8'h48);
            chk("bp_code_ready", code_ready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        exp_q.push_back(model_dec(25));
        code_q = '{12, 32, 32, 35, 11};
        run_codes(100, 0);
        check_got("bp", "HELLOK");

        // Async reset mid-message
        code_q = '{25, 12, 32, 32, 35, 11};
        run_codes(100, 3);
        rst = 1'b1;
        #1;
        reset_checks();
        code_q.delete();
        exp_q.delete();
        model_err = 1'b0;
        acc_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("key_ready_after_rst2", key_ready, 1);
        load_key("KEY");
        code_q = '{25, 12, 32, 32, 35, 11};
        run_codes(100, 0);
        check_got("after_rst", "HELLOK");

        // Random keys, codes and backpressure
        for (int it = 0; it < 6; it++) begin
            do_rekey();
            for (int i = 0; i < SEC_LEN; i++) begin
                r = int'($urandom_range(9));
                if (r == 0) kc[i] = 8'h4A;
                else if (r == 1) kc[i] = 8'h61;
                else kc[i] = 8'(65 + $urandom_range(25));
            end
            k = $sformatf("%c%c%c", kc[0], kc[1], kc[2]);
            load_key(k);
            r = 6 + int'($urandom_range(12));
            for (int i = 0; i < r; i++) begin
                if ($urandom_range(99) < 85)
                    code_q.push_back(10 * int'($urandom_range(1, 5)) + int'($urandom_range(1, 5)));
                else
                    code_q.push_back(int'($urandom_range(99)));
            end
            run_codes(60, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
